// File: rtl/alu_pkg.sv
// Shared constants for the saturating add/sub unit: operation encodings and
// saturation bound helpers used to build the clamp values at elaboration time.
package alu_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_PADD = 2'b10;
    localparam logic [1:0] MODE_PSUB = 2'b11;

    localparam int MAX_W = 64;

    // Bounds are returned as w-bit two's complement patterns in the low bits.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_lane_adder.sv
// One lane of the add/sub carry chain: optional inversion of b, lane sum,
// carry-out and the sign bits the saturation stage needs.
module sat_lane_adder #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              sa,
    output logic              sb
);

    logic [LANE_W-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{LANE_W{1'b0}}, cin};
    assign sa          = a[LANE_W-1];
    assign sb          = b_eff[LANE_W-1];

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage pipelined signed saturating add/subtract with packed lane modes
// and a valid/ready handshake; stage 1 holds raw lane sums, stage 2 clamps.
module sat_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int NL = WIDTH / LANE_W;

    localparam logic [MAX_W-1:0] W_MAX_F = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] W_MIN_F = sat_min(WIDTH);
    localparam logic [MAX_W-1:0] L_MAX_F = sat_max(LANE_W);
    localparam logic [MAX_W-1:0] L_MIN_F = sat_min(LANE_W);
    localparam logic [WIDTH-1:0]  W_MAX = W_MAX_F[WIDTH-1:0];
    localparam logic [WIDTH-1:0]  W_MIN = W_MIN_F[WIDTH-1:0];
    localparam logic [LANE_W-1:0] L_MAX = L_MAX_F[LANE_W-1:0];
    localparam logic [LANE_W-1:0] L_MIN = L_MIN_F[LANE_W-1:0];

    if ((WIDTH % LANE_W) != 0 || LANE_W < 2) begin : g_bad_params
        $error("sat_addsub_pipe: WIDTH must be a multiple of LANE_W and LANE_W >= 2");
    end

    logic             s1_adv;
    logic             in_fire;
    logic             sub_in;
    logic             packed_in;
    logic [NL-1:0]    lane_cin;
    logic [NL-1:0]    lane_cout;
    logic [NL-1:0]    lane_sa;
    logic [NL-1:0]    lane_sb;
    logic [WIDTH-1:0] lane_sum;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_packed_q, s1_packed_d;
    logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
    logic [NL-1:0]    s1_cout_q, s1_cout_d;
    logic [NL-1:0]    s1_sa_q, s1_sa_d;
    logic [NL-1:0]    s1_sb_q, s1_sb_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;

    logic [NL-1:0]    lane_ovf;
    logic [WIDTH-1:0] sat_res;
    logic             sat_v;

    assign s1_adv    = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s1_adv;
    assign in_fire   = in_valid && in_ready;
    assign sub_in    = !((mode == MODE_ADD) || (mode == MODE_PADD));
    assign packed_in = (mode == MODE_PADD) || (mode == MODE_PSUB);

    // Packed modes cut the chain at each lane; full-width modes ripple through.
    for (genvar i = 0; i < NL; i++) begin : g_lane
        if (i == 0) begin : g_first
            assign lane_cin[i] = sub_in;
        end else begin : g_rest
            assign lane_cin[i] = packed_in ? sub_in : lane_cout[i-1];
        end

        sat_lane_adder #(.LANE_W(LANE_W)) u_lane (
            .a    (a[i*LANE_W +: LANE_W]),
            .b    (b[i*LANE_W +: LANE_W]),
            .sub  (sub_in),
            .cin  (lane_cin[i]),
            .sum  (lane_sum[i*LANE_W +: LANE_W]),
            .cout (lane_cout[i]),
            .sa   (lane_sa[i]),
            .sb   (lane_sb[i])
        );
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_packed_d = s1_packed_q;
        s1_sum_d    = s1_sum_q;
        s1_cout_d   = s1_cout_q;
        s1_sa_d     = s1_sa_q;
        s1_sb_d     = s1_sb_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_packed_d = packed_in;
            s1_sum_d    = lane_sum;
            s1_cout_d   = lane_cout;
            s1_sa_d     = lane_sa;
            s1_sb_d     = lane_sb;
        end
    end

    // With equal operand signs the carry-out equals that sign, so it picks the clamp direction.
    always_comb begin
        lane_ovf = '0;
        sat_v    = 1'b0;
        sat_res  = s1_sum_q;
        for (int i = 0; i < NL; i++) begin
            lane_ovf[i] = (s1_sa_q[i] == s1_sb_q[i]) &&
                          (s1_sum_q[i*LANE_W + LANE_W - 1] != s1_sa_q[i]);
        end
        if (s1_packed_q) begin
            sat_v = |lane_ovf;
            for (int i = 0; i < NL; i++) begin
                if (lane_ovf[i]) begin
                    sat_res[i*LANE_W +: LANE_W] = s1_cout_q[i] ? L_MIN : L_MAX;
                end
            end
        end else begin
            sat_v = lane_ovf[NL-1];
            if (sat_v) begin
                sat_res = s1_cout_q[NL-1] ? W_MIN : W_MAX;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = sat_res;
                flag_z_d = (sat_res == '0);
                flag_n_d = !s1_packed_q && sat_res[WIDTH-1];
                flag_v_d = sat_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_packed_q <= 1'b0;
            s1_sum_q    <= '0;
            s1_cout_q   <= '0;
            s1_sa_q     <= '0;
            s1_sb_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_packed_q <= s1_packed_d;
            s1_sum_q    <= s1_sum_d;
            s1_cout_q   <= s1_cout_d;
            s1_sa_q     <= s1_sa_d;
            s1_sb_q     <= s1_sb_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for sat_addsub_pipe at WIDTH=16, LANE_W=4: arithmetic and
// saturation cases, stall/ordering, back-to-back throughput and mid-flight reset.
module tb_sat_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    int checks = 0;
    int fails  = 0;

    sat_addsub_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op on an idle pipe and waits (bounded) for its result.
    task automatic run_op(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output logic z, output logic n,
                          output logic v, output bit ok);
        ok = 1'b0;
        r = '0; z = 1'b0; n = 1'b0; v = 1'b0;
        out_ready = 1'b1;
        mode = m; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (out_valid) begin
                r = result; z = flag_z; n = flag_n; v = flag_v;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, result, flag_z, flag_n, flag_v} !== 20'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got valid=%b result=%h znv=%b%b%b expected all zero",
                     out_valid, result, flag_z, flag_n, flag_v);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_add();
        logic [15:0] r; logic z, n, v; bit ok;
        run_op(2'b00, 16'd20000, 16'd10000, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'd30000 || {z, n, v} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL add_basic: got ok=%b result=%h znv=%b%b%b expected %h znv=000",
                     ok, r, z, n, v, 16'd30000);
        end
        run_op(2'b00, 16'd20000, 16'd20000, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h7FFF || {z, n, v} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL add_pos_sat: got ok=%b result=%h znv=%b%b%b expected 7fff znv=001",
                     ok, r, z, n, v);
        end
    endtask

    task automatic test_sub();
        logic [15:0] r; logic z, n, v; bit ok;
        run_op(2'b01, 16'd20000, 16'd10000, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'd10000 || {z, n, v} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL sub_basic: got ok=%b result=%h znv=%b%b%b expected %h znv=000",
                     ok, r, z, n, v, 16'd10000);
        end
        run_op(2'b01, 16'hB1E0, 16'd20000, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h8000 || {z, n, v} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL sub_neg_sat: got ok=%b result=%h znv=%b%b%b expected 8000 znv=011",
                     ok, r, z, n, v);
        end
        run_op(2'b01, 16'd5, 16'd5, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h0000 || {z, n, v} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL sub_zero: got ok=%b result=%h znv=%b%b%b expected 0000 znv=100",
                     ok, r, z, n, v);
        end
    endtask

    task automatic test_packed();
        logic [15:0] r; logic z, n, v; bit ok;
        run_op(2'b10, 16'h7531, 16'h1111, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h7642 || {z, n, v} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL padd_lane_sat: got ok=%b result=%h znv=%b%b%b expected 7642 znv=001",
                     ok, r, z, n, v);
        end
        run_op(2'b11, 16'h8000, 16'h1000, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h8000 || {z, n, v} !== 3'b001) begin
            fails++;
            $display("[TB] FAIL psub_lane_sat: got ok=%b result=%h znv=%b%b%b expected 8000 znv=001",
                     ok, r, z, n, v);
        end
        run_op(2'b10, 16'h000F, 16'h0001, r, z, n, v, ok);
        checks++;
        if (!ok || r !== 16'h0000 || {z, n, v} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL padd_carry_cut: got ok=%b result=%h znv=%b%b%b expected 0000 znv=100",
                     ok, r, z, n, v);
        end
    endtask

    task automatic test_stall();
        logic [15:0] got[3];
        int cnt;
        bit xfer;
        cnt = 0;
        out_ready = 1'b0;
        mode = 2'b00; a = 16'd1; b = 16'd2; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_accept0: in_ready got %b expected 1", in_ready);
        end
        tick();
        mode = 2'b01; a = 16'd100; b = 16'd1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_accept1: in_ready got %b expected 1", in_ready);
        end
        tick();
        mode = 2'b10; a = 16'h1234; b = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 16'd3}) begin
                fails++;
                $display("[TB] FAIL stall_hold cycle %0d: got ready=%b valid=%b result=%h expected ready=0 valid=1 result=0003",
                         k, in_ready, out_valid, result);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_release_ready: in_ready got %b expected 1", in_ready);
        end
        for (int t = 0; t < 10 && cnt < 3; t++) begin
            if (out_valid) begin
                got[cnt] = result;
                cnt++;
            end
            xfer = in_valid && in_ready;
            tick();
            if (xfer) in_valid = 1'b0;
        end
        tick();
        checks++;
        if (cnt !== 3) begin
            fails++;
            $display("[TB] FAIL stall_count: got %0d results expected 3", cnt);
        end else begin
            checks++;
            if (got[0] !== 16'd3 || got[1] !== 16'd99 || got[2] !== 16'h2345) begin
                fails++;
                $display("[TB] FAIL stall_order: got %h %h %h expected 0003 0063 2345",
                         got[0], got[1], got[2]);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got[8];
        int got_t[8];
        int n;
        n = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && n < 8; t++) begin
            if (t < 8) begin
                mode = 2'b00; a = 16'(t * 100); b = 16'(t); in_valid = 1'b1;
                checks++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL b2b_in_ready op %0d: got %b expected 1", t, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid && n < 8) begin
                got[n] = result;
                got_t[n] = t;
                n++;
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (n !== 8) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d results expected 8", n);
        end else begin
            checks++;
            if (got_t[0] !== 1) begin
                fails++;
                $display("[TB] FAIL b2b_latency: first result after edge %0d expected edge 1", got_t[0]);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got[k] !== 16'(k * 101) || got_t[k] !== k + 1) begin
                    fails++;
                    $display("[TB] FAIL b2b_result %0d: got %h at edge %0d expected %h at edge %0d",
                             k, got[k], got_t[k], 16'(k * 101), k + 1);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        mode = 2'b00; a = 16'd7; b = 16'd8; in_valid = 1'b1;
        tick();
        a = 16'd1; b = 16'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result} !== {1'b1, 16'd15}) begin
            fails++;
            $display("[TB] FAIL midrst_pre: got valid=%b result=%h expected valid=1 result=000f",
                     out_valid, result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, flag_z, flag_n, flag_v} !== 20'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_async: got valid=%b result=%h znv=%b%b%b ready=%b expected zeros, ready=1",
                     out_valid, result, flag_z, flag_n, flag_v, in_ready);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midrst_stale cycle %0d: out_valid got %b expected 0", k, out_valid);
            end
        end
        mode = 2'b00; a = 16'd9; b = 16'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_early: out_valid got %b expected 0 one edge after transfer", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 16'd18}) begin
            fails++;
            $display("[TB] FAIL midrst_latency: got valid=%b result=%h expected valid=1 result=0012",
                     out_valid, result);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        mode = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_packed();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
